// File: rtl/uart_packet_rx_if.sv
// Packet receiver bus: serial line in, assembled packet and event pulses out.
interface uart_packet_rx_if;
  logic         UART_RX;
  logic [127:0] rx_data;
  logic         rx_irq;
  logic         frame_err;
  logic         timeout;

  // Receiver side: samples the line, drives packet data and pulses.
  modport master (
    input  UART_RX,
    output rx_data, rx_irq, frame_err, timeout
  );

  // Consumer side: drives the line, observes packet data and pulses.
  modport slave (
    output UART_RX,
    input  rx_data, rx_irq, frame_err, timeout
  );
endinterface

// File: rtl/uart_packet_rx.sv
// UART 8N1 receiver that assembles 16 received bytes into one 128-bit packet.
// First byte of a packet lands in the top byte of rx_data. A partial packet is
// dropped on a stop-bit error or when the line stays idle too long mid-packet.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | checking the start bit at its midpoint (rejects short glitches)
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; high accepts the byte, low is a frame error
// BREAK | line held low after a frame error, waiting for it to return high
module uart_packet_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_CLKS = 17360
) (
  input logic              clock,
  input logic              reset,
  uart_packet_rx_if.master bus
);

  localparam int unsigned IW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [15:0]   HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t         state, state_next;
  logic           rx_m, rx_s;
  logic [15:0]    tmr, tmr_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     byte_sr, byte_sr_next;
  logic [3:0]     byte_cnt, byte_cnt_next;
  logic [IW-1:0]  idle_cnt, idle_cnt_next;
  logic [127:0]   shift, shift_next;
  logic [127:0]   data_q, data_next;
  logic           irq_q, irq_next;
  logic           ferr_q, ferr_next;
  logic           tout_q, tout_next;

  // Register synchronizer, FSM state, counters, packet data and event pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      tmr      <= '0;
      bit_idx  <= '0;
      byte_sr  <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      shift    <= '0;
      data_q   <= '0;
      irq_q    <= 1'b0;
      ferr_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      rx_m     <= bus.UART_RX;
      rx_s     <= rx_m;
      state    <= state_next;
      tmr      <= tmr_next;
      bit_idx  <= bit_idx_next;
      byte_sr  <= byte_sr_next;
      byte_cnt <= byte_cnt_next;
      idle_cnt <= idle_cnt_next;
      shift    <= shift_next;
      data_q   <= data_next;
      irq_q    <= irq_next;
      ferr_q   <= ferr_next;
      tout_q   <= tout_next;
    end
  end

  // Next-state, bit timing, byte/packet assembly and pulse generation.
  always_comb begin
    state_next    = state;
    tmr_next      = tmr;
    bit_idx_next  = bit_idx;
    byte_sr_next  = byte_sr;
    byte_cnt_next = byte_cnt;
    idle_cnt_next = '0;
    shift_next    = shift;
    data_next     = data_q;
    irq_next      = 1'b0;
    ferr_next     = 1'b0;
    tout_next     = 1'b0;
    unique case (state)
      IDLE: begin
        if (byte_cnt != 4'd0) begin
          idle_cnt_next = idle_cnt + 1'b1;
          // Timeout is evaluated before the start edge so it wins a tie.
          if (idle_cnt == IDLE_LAST) begin
            idle_cnt_next = '0;
            byte_cnt_next = '0;
            tout_next     = 1'b1;
          end
        end
        if (!rx_s) begin
          state_next    = START;
          tmr_next      = '0;
          idle_cnt_next = '0;
        end
      end
      START: begin
        tmr_next = tmr + 1'b1;
        if (tmr == HALF_LAST) begin
          tmr_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        tmr_next = tmr + 1'b1;
        if (tmr == BIT_LAST) begin
          tmr_next     = '0;
          byte_sr_next = {rx_s, byte_sr[7:1]};
          bit_idx_next = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        tmr_next = tmr + 1'b1;
        if (tmr == BIT_LAST) begin
          tmr_next = '0;
          if (rx_s) begin
            state_next = IDLE;
            // Byte k goes to bits [127-8k -: 8]; {~k,3'b111} == 127-8k.
            shift_next[{~byte_cnt, 3'b111} -: 8] = byte_sr;
            byte_cnt_next = byte_cnt + 1'b1;
            if (byte_cnt == 4'hF) begin
              data_next = shift_next;
              irq_next  = 1'b1;
            end
          end else begin
            state_next    = BREAK;
            byte_cnt_next = '0;
            ferr_next     = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_irq    = irq_q;
  assign bus.frame_err = ferr_q;
  assign bus.timeout   = tout_q;

endmodule
